i2c_init_seq: RTL

//  Power-up configuration sequencer for the I2C write engine. Walks a table of NUM_REGS
//  32-bit entries {Addr, SubAddrH, SubAddrL, Data} held in an external synchronous ROM.

---
 rtl/i2c_init_seq_if.sv | 21 ++
 rtl/i2c_init_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_seq_if.sv
// Write handshake between the power-up init sequencer (master) and the I2C write engine (slave).
// Byte fields are held by the master from the write pulse until the engine reports completion.
interface i2c_init_seq_if;
  logic       write;
  logic [7:0] Addr;
  logic [7:0] SubAddrH;
  logic [7:0] SubAddrL;
  logic [7:0] Data;
  logic       ready;
  logic       errory;

  modport master (
    output write, Addr, SubAddrH, SubAddrL, Data,
    input  ready, errory
  );

  modport slave (
    input  write, Addr, SubAddrH, SubAddrL, Data,
    output ready, errory
  );
endinterface

// File: rtl/i2c_init_seq.sv
// Power-up configuration sequencer: walks a ROM table of {Addr, SubAddrH, SubAddrL, Data}
// entries, issues one I2C write per entry, retries NACKed/timed-out writes, reports done/fail.
module i2c_init_seq #(
  parameter int NUM_REGS   = 16,
  parameter int AW         = 4,
  parameter int BOOT_DELAY = 1000,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 I2C_clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [AW-1:0]        rom_addr,
  input  logic [31:0]          rom_data,
  i2c_init_seq_if.master       eng,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [AW-1:0]        fail_index
);

  localparam int CMAX_A = (BOOT_DELAY > GAP_CYCLES) ? BOOT_DELAY : GAP_CYCLES;
  localparam int CMAX   = (CMAX_A > TIMEOUT) ? CMAX_A : TIMEOUT;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_DELAY - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_BOOT      = 4'd0,
    S_FETCH     = 4'd1,
    S_LOAD      = 4'd2,
    S_ISSUE     = 4'd3,
    S_WAIT_BUSY = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_GAP       = 4'd6,
    S_DONE      = 4'd7,
    S_FAIL      = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d;
  logic          write_q, write_d;
  logic [31:0]   bytes_q, bytes_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [AW-1:0] fail_index_q, fail_index_d;

  logic          att_end_s;
  logic          att_err_s;
  logic          retry_ok_s;

  // An attempt ends when the engine completes, or when the wait in either wait state expires.
  assign att_end_s  = ((state_q == S_WAIT_BUSY) && eng.ready && (cnt_q == TO_LAST)) ||
                      ((state_q == S_WAIT_DONE) && (eng.ready || (cnt_q == TO_LAST)));
  assign att_err_s  = ((state_q == S_WAIT_DONE) && eng.ready) ? eng.errory : 1'b1;
  assign retry_ok_s = (retry_q < RETRY_MAX);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    pend_d   = pend_q;
    write_d  = 1'b0;
    bytes_d  = bytes_q;

    case (state_q)
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          cnt_d   = {CW{1'b0}};
          idx_d   = {AW{1'b0}};
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bytes_d = rom_data;
        if (rom_data[31:24] == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = {CW{1'b0}};
        if (eng.ready) begin
          write_d = 1'b1;
          state_d = S_WAIT_BUSY;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        if (att_end_s) begin
          cnt_d = {CW{1'b0}};
          if (!att_err_s) begin
            retry_d = {RW{1'b0}};
            pend_d  = 1'b0;
            state_d = S_GAP;
          end else if (retry_ok_s) begin
            retry_d = retry_q + 1'b1;
            pend_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_FAIL;
          end
        end else if ((state_q == S_WAIT_BUSY) && !eng.ready) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = {CW{1'b0}};
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = S_ISSUE;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          idx_d   = {AW{1'b0}};
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FAIL: begin
        if (start) begin
          idx_d   = {AW{1'b0}};
          retry_d = {RW{1'b0}};
          pend_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: begin
        cnt_d   = {CW{1'b0}};
        state_d = S_BOOT;
      end
    endcase

    rom_addr_d   = idx_d;
    busy_d       = (state_d != S_DONE) && (state_d != S_FAIL);
    done_d       = (state_d == S_DONE);
    fail_d       = (state_d == S_FAIL);
    fail_index_d = (state_d == S_FAIL) ? idx_q : {AW{1'b0}};
  end

  // Sequencer state and registered outputs; reset restarts from BOOT.
  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      state_q      <= S_BOOT;
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {AW{1'b0}};
      retry_q      <= {RW{1'b0}};
      pend_q       <= 1'b0;
      write_q      <= 1'b0;
      bytes_q      <= 32'h0000_0000;
      rom_addr_q   <= {AW{1'b0}};
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_index_q <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      pend_q       <= pend_d;
      write_q      <= write_d;
      bytes_q      <= bytes_d;
      rom_addr_q   <= rom_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign eng.write    = write_q;
  assign eng.Addr     = bytes_q[31:24];
  assign eng.SubAddrH = bytes_q[23:16];
  assign eng.SubAddrL = bytes_q[15:8];
  assign eng.Data     = bytes_q[7:0];
  assign rom_addr     = rom_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign fail_index   = fail_index_q;

endmodule
